nibble_serial_add_sub: RTL

//  Sequential multi-nibble add/subtract engine: one 4-bit ripple nibble per clock.

---
 rtl/add_sub_pkg.sv | 13 +
 rtl/nibble_adder.sv | 14 +
 rtl/nibble_serial_add_sub.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/add_sub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract engine.
package add_sub_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    CORR,
    DONE
  } as_state_t;

endpackage

// File: rtl/nibble_adder.sv
// 4-bit combinational ripple adder shared by the add and correction passes.
module nibble_adder
  import add_sub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  assign {cout, s} = (NIBBLE_W+1)'(a) + (NIBBLE_W+1)'(b) + (NIBBLE_W+1)'(cin);

endmodule

// File: rtl/nibble_serial_add_sub.sv
// Nibble-serial unsigned add/subtract with sign-magnitude result on valid/ready.
// Optional out_zero flag enabled by NIBBLE_SERIAL_ZERO_FLAG_EN.
module nibble_serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_m,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
  output logic                        out_cout,
  output logic                        out_neg
`ifdef NIBBLE_SERIAL_ZERO_FLAG_EN
  ,
  output logic                        out_zero
`endif
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  as_state_t        state, state_n;
  logic [W-1:0]     a_r, a_n, b_r, b_n, sum_r, sum_n;
  logic             m_r, m_n, carry, carry_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [IDX_W+1:0] base;
  logic             in_ready_n, out_valid_n, out_cout_n, out_neg_n;
  logic [W-1:0]     out_sum_n;

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
  logic                nib_ci, nib_co;

  assign base = {idx, 2'b00};

  nibble_adder u_adder (
    .a   (nib_a),
    .b   (nib_b),
    .cin (nib_ci),
    .s   (nib_s),
    .cout(nib_co)
  );

  // Next-state, datapath and registered-output selection
  always_comb begin
    state_n     = state;
    a_n         = a_r;
    b_n         = b_r;
    sum_n       = sum_r;
    m_n         = m_r;
    carry_n     = carry;
    idx_n       = idx;
    out_valid_n = out_valid;
    out_sum_n   = out_sum;
    out_cout_n  = out_cout;
    out_neg_n   = out_neg;
    nib_a       = a_r[base +: NIBBLE_W];
    nib_b       = b_r[base +: NIBBLE_W];
    nib_ci      = carry;
    if (state == CORR) begin
      nib_a = ~sum_r[base +: NIBBLE_W];
      nib_b = '0;
    end

    case (state)
      IDLE: begin
        if (in_valid) begin
          a_n     = in_a;
          b_n     = in_b ^ {W{in_m}};
          m_n     = in_m;
          carry_n = in_m;
          idx_n   = '0;
          state_n = ADD;
        end
      end
      ADD: begin
        sum_n[base +: NIBBLE_W] = nib_s;
        carry_n = nib_co;
        idx_n   = idx + 1'b1;
        if (idx == LAST) begin
          idx_n = '0;
          // Negative raw difference: seed cc=1 and negate the result
          if (m_r && !nib_co) begin
            state_n = CORR;
            carry_n = 1'b1;
          end else begin
            state_n     = DONE;
            out_valid_n = 1'b1;
            out_sum_n   = sum_n;
            out_cout_n  = nib_co;
            out_neg_n   = 1'b0;
          end
        end
      end
      CORR: begin
        sum_n[base +: NIBBLE_W] = nib_s;
        carry_n = nib_co;
        idx_n   = idx + 1'b1;
        if (idx == LAST) begin
          idx_n       = '0;
          state_n     = DONE;
          out_valid_n = 1'b1;
          out_sum_n   = sum_n;
          out_cout_n  = 1'b0;
          out_neg_n   = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n     = IDLE;
          out_valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    in_ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      sum_r     <= '0;
      m_r       <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_neg   <= 1'b0;
    end else begin
      state     <= state_n;
      a_r       <= a_n;
      b_r       <= b_n;
      sum_r     <= sum_n;
      m_r       <= m_n;
      carry     <= carry_n;
      idx       <= idx_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      out_sum   <= out_sum_n;
      out_cout  <= out_cout_n;
      out_neg   <= out_neg_n;
    end
  end

`ifdef NIBBLE_SERIAL_ZERO_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_zero <= 1'b0;
    else     out_zero <= out_valid_n && (out_sum_n == '0);
  end
`endif

endmodule
